uart_rx_logic: RTL

- UART receiver; the downstream partner of the transmit path. Consumes the serial line that the transmitter drives and returns parallel bytes to the system.
- Generates its own oversample tick from the system clock, synchronises the line, and detects and validates start bits.
- Samples data, parity and stop bits at mid-bit, then presents each byte with error flags through a valid/ready holding register.

---
 rtl/uart_rx_logic.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_logic.sv
// uart_rx_logic: oversampling UART receiver with start-bit
// validation, parity/stop checks and a valid/ready holding register.
module uart_rx_logic #(
  parameter int SYSTEM_CLK      = 125000000,
  parameter int BAUD_RATE       = 9600,
  parameter int OVERSAMPLE_RATE = 8,
  parameter int PARITY_MODE     = 0,
  parameter int STOP_MODE       = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_i_data,
  input  logic       rx_i_ready,
  output logic [7:0] rx_o_data,
  output logic       rx_o_valid,
  output logic       rx_o_parity_err,
  output logic       rx_o_frame_err,
  output logic       rx_o_overrun,
  output logic       rx_o_busy
);

  localparam int DIV = SYSTEM_CLK / (BAUD_RATE * OVERSAMPLE_RATE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OW  = $clog2(OVERSAMPLE_RATE);

  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [OW-1:0] OS_LAST   = OW'(OVERSAMPLE_RATE - 1);
  localparam logic [OW-1:0] OS_HALF   = OW'(OVERSAMPLE_RATE / 2 - 1);
  localparam logic          ODD       = (PARITY_MODE == 1);
  localparam logic          STOP_LAST = (STOP_MODE == 2);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

  state_t state, nxt;

  logic [1:0]    sync;
  logic          rxs;
  logic [DW-1:0] div_cnt;
  logic          tick;
  logic [OW-1:0] tcnt;
  logic          half_end;
  logic          bit_end;
  logic [2:0]    bidx;
  logic          sidx;
  logic [7:0]    shreg;
  logic          perr;
  logic          ferr;
  logic          ferr_now;
  logic          clr;
  logic          samp;
  logic          done;
  logic          accept;
  logic          load;

  assign rxs      = sync[1];
  assign tick     = (div_cnt == DIV_LAST);
  assign half_end = tick && (tcnt == OS_HALF);
  assign bit_end  = tick && (tcnt == OS_LAST);
  assign ferr_now = ferr | ~rxs;
  assign accept   = rx_o_valid & rx_i_ready;
  assign load     = done & (~rx_o_valid | rx_i_ready);
  assign rx_o_busy = (state != IDLE);

  // two-flop synchroniser for the asynchronous line, idles high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync <= 2'b11;
    else       sync <= {sync[0], rx_i_data};
  end

  // oversample tick divider, re-phased on every detected start edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             div_cnt <= '0;
    else if (clr || tick)  div_cnt <= '0;
    else                   div_cnt <= div_cnt + 1'b1;
  end

  // ticks elapsed since the last sample point
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             tcnt <= '0;
    else if (clr || samp)  tcnt <= '0;
    else if (tick)         tcnt <= tcnt + 1'b1;
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  // next state and sample/complete strobes
  always_comb begin
    nxt  = state;
    clr  = 1'b0;
    samp = 1'b0;
    done = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rxs) begin
          nxt = START;
          clr = 1'b1;
        end
      end
      START: begin
        if (half_end) begin
          samp = 1'b1;
          nxt  = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          samp = 1'b1;
          if (bidx == 3'd7)
            nxt = (PARITY_MODE != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_end) begin
          samp = 1'b1;
          nxt  = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          samp = 1'b1;
          if (sidx == STOP_LAST) begin
            done = 1'b1;
            nxt  = (ferr_now && !rxs) ? BREAK : IDLE;
          end
        end
      end
      BREAK: begin
        if (rxs) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // frame datapath: data shift, parity check, stop-bit tracking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bidx  <= '0;
      sidx  <= 1'b0;
      shreg <= '0;
      perr  <= 1'b0;
      ferr  <= 1'b0;
    end else if (clr) begin
      bidx <= '0;
      sidx <= 1'b0;
      perr <= 1'b0;
      ferr <= 1'b0;
    end else if (samp) begin
      case (state)
        DATA: begin
          shreg <= {rxs, shreg[7:1]};
          bidx  <= bidx + 1'b1;
        end
        PARITY: perr <= (^shreg) ^ rxs ^ ODD;
        STOP: begin
          if (!rxs) ferr <= 1'b1;
          sidx <= sidx + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // holding register with accept, drop-on-full and sticky overrun
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_o_data       <= '0;
      rx_o_valid      <= 1'b0;
      rx_o_parity_err <= 1'b0;
      rx_o_frame_err  <= 1'b0;
      rx_o_overrun    <= 1'b0;
    end else begin
      if (load) begin
        rx_o_data       <= shreg;
        rx_o_parity_err <= perr;
        rx_o_frame_err  <= ferr_now;
        rx_o_valid      <= 1'b1;
      end else if (accept) begin
        rx_o_valid <= 1'b0;
      end
      if (done && rx_o_valid && !rx_i_ready)
        rx_o_overrun <= 1'b1;
      else if (accept)
        rx_o_overrun <= 1'b0;
    end
  end

endmodule
